// File: rtl/text_render_ctrl_pkg.sv
// Shared constants and FSM encoding for the text overlay renderer.
package text_pkg;

    localparam int GLYPH_W   = 8;   // pixels per glyph row
    localparam int GLYPH_H   = 16;  // rows per glyph
    localparam int CHAR_W    = 7;   // character code width
    localparam int ROM_AW    = 11;  // {char[6:0], glyph_row[3:0]}
    localparam int BUF_DEPTH = 64;  // character cells
    localparam int BUF_AW    = 6;   // character cell index width

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/text_render_ctrl_if.sv
// Host-side character buffer port of the text overlay renderer.
//
// Handshake: wr_en and clr are single-cycle strobes sampled on the rising
// edge of clk. busy acts as an inverted ready: while busy is high every
// strobe is discarded. In IDLE a clr strobe wins over a simultaneous wr_en,
// and the write is discarded. There is no other flow control.
interface text_render_ctrl_if;

    logic                        wr_en;
    logic [text_pkg::BUF_AW-1:0] wr_addr;
    logic [text_pkg::CHAR_W-1:0] wr_data;
    logic                        clr;
    logic                        busy;

    modport master (output wr_en, output wr_addr, output wr_data, output clr, input busy);
    modport slave  (input wr_en, input wr_addr, input wr_data, input clr, output busy);

endinterface

// File: rtl/text_render_ctrl_char_buf.sv
// 64 x 7 character buffer: one synchronous write port, one combinational
// read port. A read in the same cycle as a write to that entry sees the
// old contents because the array only changes on the clock edge.
module text_char_buf
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [BUF_AW-1:0] raddr,
    output logic [CHAR_W-1:0] rdata
);

    logic [CHAR_W-1:0] mem [BUF_DEPTH];

    // Storage array; reset blanks every cell at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/text_render_ctrl.sv
// Text overlay renderer: maps VGA pixel coordinates onto a COLS x ROWS
// character window, fetches glyph rows from an external registered font
// ROM and produces a glyph pixel three cycles after the coordinates,
// with the sync/enable controls delayed to match. A small FSM blanks the
// character buffer on request while rendering continues.
module text_render_ctrl
    import text_pkg::*;
#(
    parameter int WIN_X0 = 64,
    parameter int WIN_Y0 = 64,
    parameter int COLS   = 16,
    parameter int ROWS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    text_render_ctrl_if.slave host,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              pixel_on,
    output logic              video_on_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output state_t            fsm_state
);

    localparam int WIN_W = COLS * GLYPH_W;
    localparam int WIN_H = ROWS * GLYPH_H;

    // Window decode; compared at 11 bits so the right/bottom bound cannot wrap.
    logic              in_x, in_y, in_win;
    logic [9:0]        dx, dy;
    logic [BUF_AW-1:0] rd_addr;
    logic [CHAR_W-1:0] rd_char;

    assign in_x   = ({1'b0, pixel_x} >= 11'(WIN_X0)) && ({1'b0, pixel_x} < 11'(WIN_X0 + WIN_W));
    assign in_y   = ({1'b0, pixel_y} >= 11'(WIN_Y0)) && ({1'b0, pixel_y} < 11'(WIN_Y0 + WIN_H));
    assign in_win = in_x && in_y;
    // Offsets forced to zero outside the window so no underflowed value escapes.
    assign dx      = in_win ? (pixel_x - 10'(WIN_X0)) : '0;
    assign dy      = in_win ? (pixel_y - 10'(WIN_Y0)) : '0;
    assign rd_addr = BUF_AW'(dy[9:4] * COLS + dx[9:3]);

    // Clear FSM and buffer write arbitration.
    state_t            state_q, state_d;
    logic [BUF_AW-1:0] ptr_q, ptr_d;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_waddr;
    logic [CHAR_W-1:0] buf_wdata;

    // State and clear pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: clr beats a host write in IDLE; CLEAR owns the write port.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        buf_we    = host.wr_en;
        buf_waddr = host.wr_addr;
        buf_wdata = host.wr_data;
        case (state_q)
            ST_IDLE: begin
                if (host.clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    buf_we  = 1'b0;
                end
            end
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_waddr = ptr_q;
                buf_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == BUF_AW'(BUF_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign host.busy = (state_q == ST_CLEAR);
    assign fsm_state = state_q;

    text_char_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (rd_addr),
        .rdata (rd_char)
    );

    // Stage 1: character lookup and glyph position.
    logic [CHAR_W-1:0] s1_char;
    logic [3:0]        s1_row;
    logic [2:0]        s1_bit;
    logic              s1_win, s1_vid, s1_hs, s1_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_char <= '0;
            s1_row  <= '0;
            s1_bit  <= '0;
            s1_win  <= 1'b0;
            s1_vid  <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
        end else begin
            s1_char <= rd_char;
            s1_row  <= dy[3:0];
            s1_bit  <= dx[2:0];
            s1_win  <= in_win;
            s1_vid  <= video_on;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
        end
    end

    assign rom_addr = {s1_char, s1_row};

    // Stage 2: ride alongside the ROM's own address register.
    logic [2:0] s2_bit;
    logic       s2_win, s2_vid, s2_hs, s2_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_bit <= '0;
            s2_win <= 1'b0;
            s2_vid <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
        end else begin
            s2_bit <= s1_bit;
            s2_win <= s1_win;
            s2_vid <= s1_vid;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    // Stage 3: pick the glyph bit (bit 7 is leftmost) and emit the controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on     <= 1'b0;
            video_on_out <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            pixel_on     <= s2_win & s2_vid & rom_data[3'd7 - s2_bit];
            video_on_out <= s2_vid;
            hsync_out    <= s2_hs;
            vsync_out    <= s2_vs;
        end
    end

endmodule

// File: tb/tb_text_render_ctrl.sv
// Directed bench for text_render_ctrl with a behavioural registered font ROM.
module tb_text_render_ctrl;
    import text_pkg::*;

    localparam int SIG_ROM   = 0;
    localparam int SIG_PIX   = 1;
    localparam int SIG_BUSY  = 2;
    localparam int SIG_VO    = 3;
    localparam int SIG_HS    = 4;
    localparam int SIG_VS    = 5;
    localparam int SIG_CHR   = 6;
    localparam int SIG_STATE = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT and ROM model ----------------
    text_render_ctrl_if bus ();

    logic [9:0]        pixel_x, pixel_y;
    logic              video_on, hsync_in, vsync_in;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              pixel_on, video_on_out, hsync_out, vsync_out;
    state_t            fsm_state;

    text_render_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (bus),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .pixel_on     (pixel_on),
        .video_on_out (video_on_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .fsm_state    (fsm_state)
    );

    // Font: char 0x31 row 2 is 00011000; blank char is empty; others hashed.
    function automatic logic [7:0] font(input logic [10:0] a);
        if (a == 11'h312) return 8'h18;
        if (a[10:4] == 7'h00) return 8'h00;
        return 8'hA5 ^ a[7:0];
    endfunction

    logic [10:0] rom_aq = '0;
    always @(posedge clk) rom_aq <= rom_addr;
    assign rom_data = font(rom_aq);

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        int          sig;
        logic [10:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mi;

    function automatic string sig_name(input int s);
        case (s)
            SIG_ROM:   return "rom_addr";
            SIG_PIX:   return "pixel_on";
            SIG_BUSY:  return "busy";
            SIG_VO:    return "video_on_out";
            SIG_HS:    return "hsync_out";
            SIG_VS:    return "vsync_out";
            SIG_CHR:   return "rom_addr_char";
            default:   return "fsm_state";
        endcase
    endfunction

    function automatic logic [10:0] actual(input int s);
        case (s)
            SIG_ROM:   return rom_addr;
            SIG_PIX:   return {10'd0, pixel_on};
            SIG_BUSY:  return {10'd0, bus.busy};
            SIG_VO:    return {10'd0, video_on_out};
            SIG_HS:    return {10'd0, hsync_out};
            SIG_VS:    return {10'd0, vsync_out};
            SIG_CHR:   return {4'd0, rom_addr[10:4]};
            default:   return {10'd0, fsm_state};
        endcase
    endfunction

    // Monitor: every falling edge, retire the expectations due this cycle.
    always @(negedge clk) begin
        mi = 0;
        while (mi < exp_q.size()) begin
            if (exp_q[mi].cyc == cyc) begin
                checks++;
                if (actual(exp_q[mi].sig) !== exp_q[mi].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h",
                             sig_name(exp_q[mi].sig), cyc, actual(exp_q[mi].sig), exp_q[mi].val);
                end
                exp_q.delete(mi);
            end else if (exp_q[mi].cyc < cyc) begin
                errors++;
                $display("FAIL stale_%s cyc=%0d due=%0d", sig_name(exp_q[mi].sig), cyc, exp_q[mi].cyc);
                exp_q.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [10:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic set_pix(input int x, input int y, input logic vid, input logic hs, input logic vs);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vid;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic set_cell(input int a);
        set_pix(64 + 8 * (a % 16), 64 + 16 * (a / 16), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic write_char(input int a, input logic [6:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(a);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] pat [8] = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b110, 3'b001, 3'b011, 3'b100};
    int n0;

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.clr = 1'b0;
        set_pix(70, 70, 1'b1, 1'b1, 1'b1);

        // Reset: outputs held low even with active inputs.
        tick(); tick();
        expect_at(cyc, SIG_ROM, 11'h000);
        expect_at(cyc, SIG_PIX, 11'd0);
        expect_at(cyc, SIG_BUSY, 11'd0);
        expect_at(cyc, SIG_VO, 11'd0);
        expect_at(cyc, SIG_HS, 11'd0);
        expect_at(cyc, SIG_VS, 11'd0);
        expect_at(cyc, SIG_STATE, 11'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // Glyph fetch and pixel selection.
        write_char(0, 7'h31);
        set_pix(64, 66, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, SIG_ROM, 11'h312); expect_at(cyc + 3, SIG_PIX, 11'd0); tick();
        set_pix(67, 66, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, SIG_ROM, 11'h312); expect_at(cyc + 3, SIG_PIX, 11'd1); tick();
        set_pix(67, 66, 1'b0, 1'b0, 1'b0);
        expect_at(cyc + 3, SIG_PIX, 11'd0); tick();
        set_pix(192, 66, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 3, SIG_PIX, 11'd0); tick();
        set_pix(63, 66, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 3, SIG_PIX, 11'd0); tick();
        set_pix(191, 66, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, SIG_ROM, 11'h002); tick();
        write_char(17, 7'h31);
        set_pix(75, 82, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, SIG_ROM, 11'h312); expect_at(cyc + 3, SIG_PIX, 11'd1); tick();
        write_char(48, 7'h41);
        set_pix(64, 127, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, SIG_ROM, 11'h41F); expect_at(cyc + 3, SIG_PIX, 11'd1); tick();
        set_pix(64, 128, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 3, SIG_PIX, 11'd0); tick();

        // Same-cycle write and read of one entry: old value first.
        bus.wr_en = 1'b1; bus.wr_addr = 6'd0; bus.wr_data = 7'h22;
        set_pix(64, 66, 1'b1, 1'b0, 1'b0);
        expect_at(cyc + 1, SIG_ROM, 11'h312); tick();
        bus.wr_en = 1'b0;
        expect_at(cyc + 1, SIG_ROM, 11'h222); tick();

        // Control delay pattern.
        for (int i = 0; i < 8; i++) begin
            set_pix(0, 0, pat[i][2], pat[i][1], pat[i][0]);
            expect_at(cyc + 3, SIG_VO, {10'd0, pat[i][2]});
            expect_at(cyc + 3, SIG_HS, {10'd0, pat[i][1]});
            expect_at(cyc + 3, SIG_VS, {10'd0, pat[i][0]});
            tick();
        end
        set_pix(0, 0, 1'b0, 1'b0, 1'b0);

        // Clear sequence with ignored strobes and live rendering.
        write_char(40, 7'h22);
        bus.clr = 1'b1; n0 = cyc;
        expect_at(n0 + 1, SIG_BUSY, 11'd1);
        expect_at(n0 + 1, SIG_STATE, 11'(ST_CLEAR));
        expect_at(n0 + 64, SIG_BUSY, 11'd1);
        expect_at(n0 + 65, SIG_BUSY, 11'd0);
        tick();
        bus.clr = 1'b0;
        while (cyc < n0 + 70) begin
            if (cyc == n0 + 10) begin set_cell(40); expect_at(cyc + 1, SIG_CHR, 11'h22); end
            if (cyc == n0 + 30) bus.clr = 1'b1;
            if (cyc == n0 + 31) bus.clr = 1'b0;
            if (cyc == n0 + 41) begin bus.wr_en = 1'b1; bus.wr_addr = 6'd2; bus.wr_data = 7'h55; end
            if (cyc == n0 + 42) bus.wr_en = 1'b0;
            if (cyc == n0 + 50) begin set_cell(40); expect_at(cyc + 1, SIG_CHR, 11'h00); end
            tick();
        end
        for (int a = 0; a < 64; a++) begin
            set_cell(a);
            expect_at(cyc + 1, SIG_CHR, 11'h00);
            tick();
        end

        // clr and wr_en together in IDLE: clr wins, write dropped.
        write_char(3, 7'h10);
        bus.wr_en = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 7'h7F; bus.clr = 1'b1;
        expect_at(cyc + 1, SIG_BUSY, 11'd1);
        tick();
        bus.wr_en = 1'b0; bus.clr = 1'b0;
        set_cell(3);
        expect_at(cyc + 1, SIG_CHR, 11'h10);
        tick();
        repeat (70) tick();

        // Reset during clear aborts it; a fresh clr restarts from entry 0.
        write_char(63, 7'h11);
        bus.clr = 1'b1; n0 = cyc;
        tick();
        bus.clr = 1'b0;
        while (cyc < n0 + 21) tick();
        rst_n = 1'b0;
        expect_at(cyc, SIG_BUSY, 11'd0);
        expect_at(cyc, SIG_ROM, 11'h000);
        tick(); tick();
        rst_n = 1'b1;
        set_cell(63);
        expect_at(cyc, SIG_BUSY, 11'd0);
        expect_at(cyc + 1, SIG_CHR, 11'h00);
        tick();
        bus.clr = 1'b1; n0 = cyc;
        expect_at(n0 + 64, SIG_BUSY, 11'd1);
        expect_at(n0 + 65, SIG_BUSY, 11'd0);
        tick();
        bus.clr = 1'b0;
        while (cyc < n0 + 70) tick();

        // Drain and report.
        repeat (5) tick();
        while (exp_q.size() > 0) begin
            errors++;
            $display("FAIL unchecked_%s due=%0d", sig_name(exp_q[0].sig), exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog bounds the run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d limit=20000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
